// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer. Owns the PC, applies LUT jump targets
// (absolute or PC-relative), keeps a call/return stack and runs start/halt control.
module pc_sequencer #(
  parameter int D  = 10,
  parameter int SD = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         halt_req,
  input  logic         branch_en,
  input  logic         branch_rel,
  input  logic         call,
  input  logic         ret,
  input  logic [3:0]   lut_idx,
  output logic [3:0]   lut_addr,
  input  logic [D-1:0] lut_target,
  output logic [D-1:0] prog_ctr,
  output logic         running,
  output logic         done,
  output logic         stack_ovf,
  output logic         stack_unf
);

  localparam int AW  = $clog2(SD);
  localparam int SPW = AW + 1;
  localparam logic [D-1:0]   PC_ONE  = D'(1);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(SD);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, next_state;
  logic [D-1:0]   stack_mem [SD];
  logic [SPW-1:0] sp, sp_dec;
  logic [D-1:0]   pc_inc, jump_target, next_pc;
  logic           push, pop, set_ovf, set_unf, clear;

  assign lut_addr = lut_idx;
  assign pc_inc   = prog_ctr + PC_ONE;
  assign sp_dec   = sp - SP_ONE;
  // Relative mode relies on modular D-bit addition for negative offsets.
  assign jump_target = branch_rel ? (prog_ctr + lut_target) : lut_target;

  always_comb begin
    next_state = state;
    next_pc    = prog_ctr;
    push       = 1'b0;
    pop        = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    clear      = 1'b0;
    if (!stall) begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            next_state = RUN;
            next_pc    = '0;
            clear      = 1'b1;
          end
        end
        RUN: begin
          if (halt_req) begin
            next_state = DONE;
          end else if (ret) begin
            if (sp != '0) begin
              pop     = 1'b1;
              next_pc = stack_mem[sp_dec[AW-1:0]];
            end else begin
              set_unf = 1'b1;
              next_pc = pc_inc;
            end
          end else if (call) begin
            if (sp != SP_FULL) begin
              push    = 1'b1;
              next_pc = jump_target;
            end else begin
              set_ovf = 1'b1;
              next_pc = pc_inc;
            end
          end else if (branch_en) begin
            next_pc = jump_target;
          end else begin
            next_pc = pc_inc;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prog_ctr  <= '0;
      sp        <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
      for (int i = 0; i < SD; i++) stack_mem[i] <= '0;
    end else begin
      state    <= next_state;
      prog_ctr <= next_pc;
      running  <= (next_state == RUN);
      done     <= (next_state == DONE);
      if (clear) begin
        sp        <= '0;
        stack_ovf <= 1'b0;
        stack_unf <= 1'b0;
      end else begin
        if (push) begin
          stack_mem[sp[AW-1:0]] <= pc_inc;
          sp                    <= sp + SP_ONE;
        end
        if (pop)     sp        <= sp_dec;
        if (set_ovf) stack_ovf <= 1'b1;
        if (set_unf) stack_unf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized plus directed bench for pc_sequencer, checked against a
// behavioural model built from a mode flag, an integer PC and a queue stack.
module tb_pc_sequencer;

  localparam int D    = 10;
  localparam int SD   = 4;
  localparam int MODV = 1 << D;

  logic         clk = 1'b0;
  logic         reset, start, stall, halt_req, branch_en, branch_rel, call, ret;
  logic [3:0]   lut_idx, lut_addr;
  logic [D-1:0] lut_target, prog_ctr;
  logic         running, done, stack_ovf, stack_unf;

  logic [D-1:0] lut_mem [16];

  int checks = 0;
  int errors = 0;

  // Behavioural model: 0 = idle, 1 = run, 2 = done
  int m_mode;
  int m_pc;
  int m_stack[$];
  bit m_ovf, m_unf;

  always #5 clk = ~clk;

  assign lut_target = lut_mem[lut_addr];

  pc_sequencer #(.D(D), .SD(SD)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .halt_req(halt_req), .branch_en(branch_en), .branch_rel(branch_rel),
    .call(call), .ret(ret), .lut_idx(lut_idx), .lut_addr(lut_addr),
    .lut_target(lut_target), .prog_ctr(prog_ctr), .running(running),
    .done(done), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int target_of(input int pc, input int idx, input bit rel);
    int raw, offset;
    raw = int'(lut_mem[idx]);
    if (!rel) return raw;
    offset = (raw >= MODV / 2) ? raw - MODV : raw;
    return ((pc + offset) % MODV + MODV) % MODV;
  endfunction

  task automatic model_step();
    int tgt;
    if (reset) begin
      m_mode = 0; m_pc = 0; m_stack.delete(); m_ovf = 0; m_unf = 0;
      return;
    end
    if (stall) return;
    if (m_mode != 1) begin
      if (start) begin
        m_mode = 1; m_pc = 0; m_stack.delete(); m_ovf = 0; m_unf = 0;
      end
      return;
    end
    tgt = target_of(m_pc, int'(lut_idx), branch_rel);
    if (halt_req) m_mode = 2;
    else if (ret) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin m_unf = 1; m_pc = (m_pc + 1) % MODV; end
    end else if (call) begin
      if (m_stack.size() < SD) begin
        m_stack.push_back((m_pc + 1) % MODV);
        m_pc = tgt;
      end else begin
        m_ovf = 1; m_pc = (m_pc + 1) % MODV;
      end
    end else if (branch_en) m_pc = tgt;
    else m_pc = (m_pc + 1) % MODV;
  endtask

  task automatic clear_inputs();
    reset = 0; start = 0; stall = 0; halt_req = 0;
    branch_en = 0; branch_rel = 0; call = 0; ret = 0; lut_idx = '0;
  endtask

  // Inputs are already driven; settle, model the edge, then compare after it.
  task automatic applyStimulus();
    #1;
    checkOutput("lut_addr", 32'(lut_addr), 32'(lut_idx));
    model_step();
    @(posedge clk);
    #1;
    checkOutput("prog_ctr", 32'(prog_ctr), 32'(m_pc));
    checkOutput("running", 32'(running), 32'(m_mode == 1));
    checkOutput("done", 32'(done), 32'(m_mode == 2));
    checkOutput("stack_ovf", 32'(stack_ovf), 32'(m_ovf));
    checkOutput("stack_unf", 32'(stack_unf), 32'(m_unf));
  endtask

  task automatic run_free(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic do_jump(input bit is_call, input int idx, input bit rel);
    clear_inputs();
    if (is_call) call = 1; else branch_en = 1;
    lut_idx = 4'(idx); branch_rel = rel;
    applyStimulus();
  endtask

  task automatic do_ret();
    clear_inputs(); ret = 1; applyStimulus();
  endtask

  task automatic do_start();
    clear_inputs(); start = 1; applyStimulus();
  endtask

  task automatic do_halt();
    clear_inputs(); halt_req = 1; applyStimulus();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) lut_mem[i] = D'($urandom_range(0, MODV - 1));
    lut_mem[1] = 10'd11;  lut_mem[2] = 10'd44;  lut_mem[3] = 10'd1019;
    lut_mem[5] = 10'd30;  lut_mem[7] = 10'd35;  lut_mem[8] = 10'd20;
    m_mode = 0; m_pc = 0; m_ovf = 0; m_unf = 0;

    clear_inputs(); reset = 1;
    applyStimulus(); applyStimulus();

    // Build PC=37 with two stack entries, then reset mid-run
    do_start();
    do_jump(1, 5, 0);
    do_jump(1, 7, 0);
    run_free(2);
    checkOutput("pc_before_reset", 32'(prog_ctr), 32'd37);
    clear_inputs(); reset = 1; applyStimulus();
    checkOutput("reset_pc", 32'(prog_ctr), 32'd0);
    do_start();
    run_free(3);
    do_ret();
    checkOutput("unf_after_reset", 32'(stack_unf), 32'd1);

    // Branches: absolute, relative, negative relative, wrap
    do_halt(); do_start(); run_free(5);
    do_jump(0, 2, 0);
    checkOutput("abs_branch", 32'(prog_ctr), 32'd44);
    do_jump(0, 1, 1);
    checkOutput("rel_branch", 32'(prog_ctr), 32'd55);
    do_halt(); do_start(); run_free(3);
    do_jump(0, 3, 1);
    checkOutput("neg_rel_branch", 32'(prog_ctr), 32'd1022);
    run_free(2);
    checkOutput("pc_wrap", 32'(prog_ctr), 32'd0);

    // Call/return, overflow and underflow
    do_halt(); do_start(); run_free(10);
    do_jump(1, 2, 0);
    checkOutput("call_target", 32'(prog_ctr), 32'd44);
    do_ret();
    checkOutput("ret_addr", 32'(prog_ctr), 32'd11);
    for (int i = 0; i < 5; i++) do_jump(1, 2, 0);
    checkOutput("ovf_flag", 32'(stack_ovf), 32'd1);
    checkOutput("ovf_pc", 32'(prog_ctr), 32'd45);
    for (int i = 0; i < 5; i++) do_ret();
    checkOutput("unf_flag", 32'(stack_unf), 32'd1);

    // Stall holds everything, then a released branch is taken
    clear_inputs(); stall = 1; branch_en = 1; call = 1; halt_req = 1; lut_idx = 4'd2;
    for (int i = 0; i < 3; i++) applyStimulus();
    do_jump(0, 2, 0);
    checkOutput("post_stall_jump", 32'(prog_ctr), 32'd44);

    // All requests together at PC 20: halt wins
    do_jump(0, 8, 0);
    clear_inputs(); halt_req = 1; ret = 1; call = 1; branch_en = 1; lut_idx = 4'd2;
    applyStimulus();
    checkOutput("halt_pc", 32'(prog_ctr), 32'd20);
    clear_inputs(); ret = 1; call = 1; branch_en = 1; applyStimulus();
    do_start();
    checkOutput("restart_ovf", 32'(stack_ovf), 32'd0);

    // start ignored while running
    run_free(8);
    do_start();
    checkOutput("start_in_run", 32'(prog_ctr), 32'd9);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if (n % 100 == 0)
        for (int i = 0; i < 16; i++) lut_mem[i] = D'($urandom_range(0, MODV - 1));
      clear_inputs();
      reset      = ($urandom_range(0, 79) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      start      = ($urandom_range(0, 7) == 0);
      halt_req   = ($urandom_range(0, 19) == 0);
      ret        = ($urandom_range(0, 4) == 0);
      call       = ($urandom_range(0, 4) == 0);
      branch_en  = ($urandom_range(0, 3) == 0);
      branch_rel = 1'($urandom_range(0, 1));
      lut_idx    = 4'($urandom_range(0, 15));
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
